// File: rtl/div_unit.sv
// div_unit: multi-cycle 32-bit radix-2 restoring divider for DIV/DIVU.
// Produces one quotient bit per clock. Division by zero takes a short path
// that returns zero. result_o = {remainder, quotient}. Both outputs are registered.
// Build option: define DIV_SIGNED_EN to enable signed (DIV) operation.
// Without it, signed_div_i is ignored and every divide is unsigned.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {
        ST_FREE    = 2'd0,
        ST_BY_ZERO = 2'd1,
        ST_ON      = 2'd2,
        ST_END     = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [64:0] work_q, work_d;
    logic [31:0] divisor_q, divisor_d;
    logic [63:0] result_q, result_d;
    logic        ready_q, ready_d;

    logic [31:0] abs_a_s;
    logic [31:0] abs_b_s;
    logic [32:0] diff_s;
    logic [64:0] next_work_s;
    logic [31:0] quot_s;
    logic [31:0] rem_s;

`ifdef DIV_SIGNED_EN
    logic        neg_quot_q, neg_quot_d;
    logic        neg_rem_q, neg_rem_d;
    logic        sgn_s;

    // Two's-complement magnitude, applied only to negative operands in signed mode
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic en);
        abs32 = (en && v[31]) ? (~v + 32'd1) : v;
    endfunction

    // Conditional two's-complement negation used for the sign fixup
    function automatic logic [31:0] neg32(input logic [31:0] v, input logic en);
        neg32 = en ? (~v + 32'd1) : v;
    endfunction

    assign sgn_s   = signed_div_i;
    assign abs_a_s = abs32(opdata1_i, sgn_s);
    assign abs_b_s = abs32(opdata2_i, sgn_s);
    assign quot_s  = neg32(next_work_s[31:0], neg_quot_q);
    assign rem_s   = neg32(next_work_s[64:33], neg_rem_q);
`else
    // Signed mode is not built, so the mode input is intentionally left without a load
    logic        sign_unused_s;

    assign sign_unused_s = signed_div_i;
    assign abs_a_s       = opdata1_i;
    assign abs_b_s       = opdata2_i;
    assign quot_s        = next_work_s[31:0];
    assign rem_s         = next_work_s[64:33];
`endif

    // One restoring step: trial-subtract the divisor from the partial remainder
    always_comb begin
        diff_s = work_q[64:32] - {1'b0, divisor_q};
        if (diff_s[32]) begin
            next_work_s = {work_q[63:0], 1'b0};
        end else begin
            next_work_s = {diff_s[31:0], work_q[31:0], 1'b1};
        end
    end

    // Next-state, operand-latch and registered-output logic of the divider FSM
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        divisor_d = divisor_q;
        result_d  = result_q;
        ready_d   = ready_q;
`ifdef DIV_SIGNED_EN
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
`endif
        case (state_q)
            ST_FREE: begin
                result_d = 64'd0;
                ready_d  = 1'b0;
                if (start_i && !annul_i) begin
                    if (opdata2_i == 32'd0) begin
                        state_d = ST_BY_ZERO;
                    end else begin
                        state_d   = ST_ON;
                        cnt_d     = 6'd0;
                        work_d    = {32'd0, abs_a_s, 1'b0};
                        divisor_d = abs_b_s;
`ifdef DIV_SIGNED_EN
                        neg_quot_d = sgn_s & (opdata1_i[31] ^ opdata2_i[31]);
                        neg_rem_d  = sgn_s & opdata1_i[31];
`endif
                    end
                end else begin
                    state_d = ST_FREE;
                end
            end
            ST_BY_ZERO: begin
                // A flush also cancels the zero-divisor shortcut
                if (annul_i) begin
                    state_d  = ST_FREE;
                    result_d = 64'd0;
                    ready_d  = 1'b0;
                end else begin
                    state_d  = ST_END;
                    result_d = 64'd0;
                    ready_d  = 1'b1;
                end
            end
            ST_ON: begin
                if (annul_i) begin
                    state_d  = ST_FREE;
                    cnt_d    = 6'd0;
                    result_d = 64'd0;
                    ready_d  = 1'b0;
                end else begin
                    work_d = next_work_s;
                    cnt_d  = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        state_d  = ST_END;
                        result_d = {rem_s, quot_s};
                        ready_d  = 1'b1;
                    end else begin
                        state_d = ST_ON;
                    end
                end
            end
            ST_END: begin
                if (annul_i || !start_i) begin
                    state_d  = ST_FREE;
                    result_d = 64'd0;
                    ready_d  = 1'b0;
                end else begin
                    state_d = ST_END;
                end
            end
            default: begin
                state_d  = ST_FREE;
                cnt_d    = 6'd0;
                result_d = 64'd0;
                ready_d  = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FREE;
            cnt_q     <= 6'd0;
            work_q    <= 65'd0;
            divisor_q <= 32'd0;
            result_q  <= 64'd0;
            ready_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            divisor_q <= divisor_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
`ifdef DIV_SIGNED_EN
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
`endif
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard testbench for div_unit: expected results are queued at launch
// and compared against result_o when ready_o rises.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] sb_q[$];

`ifdef DIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    div_unit dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference divide: {remainder, quotient}, zero for a zero divisor
    function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        int sa;
        int sb;
        if (b == 32'd0) return 64'd0;
        q = a / b;
        r = a % b;
        if (sgn && SIGNED_EN) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                r = 32'd0;
            end else begin
                sa = a;
                sb = b;
                q = sa / sb;
                r = sa % sb;
            end
        end
        return {r, q};
    endfunction

    // Launch one divide, wait for ready, check latency/result, then release
    task automatic run_op(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input string tag);
        int n;
        bit got;
        logic [63:0] exp;
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        sb_q.push_back(model(sgn, a, b));
        n   = 0;
        got = 1'b0;
        while (n < 80 && !got) begin
            tick();
            n++;
            // Operands must have been captured; disturb the inputs
            opdata1_i    = $urandom;
            opdata2_i    = $urandom;
            signed_div_i = $urandom_range(1, 0);
            if (ready_o) got = 1'b1;
        end
        check_eq({tag, "_latency"}, 64'(n), 64'(lat));
        exp = sb_q.pop_front();
        check_eq({tag, "_result"}, result_o, exp);
        tick();
        check_eq({tag, "_hold_ready"}, 64'(ready_o), 64'd1);
        check_eq({tag, "_hold_result"}, result_o, exp);
        start_i = 1'b0;
        tick();
        check_eq({tag, "_rel_ready"}, 64'(ready_o), 64'd0);
        check_eq({tag, "_rel_result"}, result_o, 64'd0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        bit rs;
        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        @(negedge clk);
        tick();
        tick();
        check_eq("reset_ready", 64'(ready_o), 64'd0);
        check_eq("reset_result", result_o, 64'd0);
        rst = 1'b0;
        tick();

        run_op(1'b0, 32'd100, 32'd7, 33, "divu_100_7");
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 33, "div_m7_2");
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 33, "div_7_m2");
        run_op(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 33, "div_m100_m7");
        run_op(1'b0, 32'd5, 32'd0, 2, "div_by_zero");
        run_op(1'b1, 32'd5, 32'd0, 2, "sdiv_by_zero");
        run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 33, "divu_max_1");
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, "div_min_m1");
        run_op(1'b0, 32'd3, 32'hFFFF_FFFF, 33, "divu_3_max");
        run_op(1'b0, 32'd0, 32'd9, 33, "divu_0_9");

        // Annul mid-operation: ready must never rise
        signed_div_i = 1'b0;
        opdata1_i    = 32'd50;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("annul_busy_ready", 64'(ready_o), 64'd0);
        end
        annul_i = 1'b1;
        tick();
        check_eq("annul_ready", 64'(ready_o), 64'd0);
        check_eq("annul_result", result_o, 64'd0);
        annul_i = 1'b0;
        start_i = 1'b0;
        tick();
        check_eq("annul_idle_ready", 64'(ready_o), 64'd0);
        run_op(1'b0, 32'd9, 32'd3, 33, "after_annul_9_3");

        // Reset mid-operation
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        rst = 1'b1;
        tick();
        check_eq("midrst_ready", 64'(ready_o), 64'd0);
        check_eq("midrst_result", result_o, 64'd0);
        rst     = 1'b0;
        start_i = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            check_eq("midrst_idle_ready", 64'(ready_o), 64'd0);
        end
        run_op(1'b0, 32'd1000, 32'd3, 33, "after_rst");

        // Random operands, both modes
        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = (i % 2 == 0) ? 32'($urandom_range(1000, 1)) : $urandom;
            if (rb == 32'd0) rb = 32'd1;
            rs = $urandom_range(1, 0);
            run_op(rs, ra, rb, 33, "random");
        end

        check_eq("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider serving the DIV/DIVU instructions of the five-stage MIPS pipeline. It sits beside the execute stage. Execute launches it with latched operands and holds the pipeline stalled while the divider runs. The 64-bit result then returns to execute, which forwards it as the HI/LO write-back (HI = remainder, LO = quotient). The divider is a radix-2 restoring design: one quotient bit per clock, with a short path for division by zero.

## Interface
No parameters; datapath fixed at 32 bits.

- clk  in  1  rising-edge clock
- rst  in  1  reset rst, synchronous, active-high
- signed_div_i  in  1  1 = DIV (signed), 0 = DIVU
- opdata1_i  in  32  dividend
- opdata2_i  in  32  divisor
- start_i  in  1  request/hold; execute keeps it high until it has consumed the result
- annul_i  in  1  cancel; used on pipeline flush (exception, branch-likely squash)
- result_o  out  64  {remainder, quotient}; registered
- ready_o  out  1  result valid; registered

## Operation
- **States.**
  - FREE: idle; result_o = 0, ready_o = 0.
  - BY_ZERO: one cycle; divisor was 0.
  - ON: iterating; 6-bit counter cnt counts 0..32.
  - END: result held; ready_o = 1.
- **FREE.**
  - start_i=1 and annul_i=0 with opdata2_i=0: go to BY_ZERO.
  - start_i=1 and annul_i=0 with opdata2_i≠0: go to ON. On the same edge, latch operands and signs, load the working register {32'b0, |dividend|, 1'b0}, and set cnt=0.
  - Otherwise stay in FREE.
- **Operand latching.** opdata*_i are sampled only on the FREE→ON edge. Later changes on the inputs are ignored.
- **ON, per edge.**
  - Compute the 33-bit difference = working[64:32] − {1'b0, |divisor|}.
  - If the difference is negative: working = working << 1 (quotient bit 0).
  - Otherwise: working = {difference[31:0], working[31:0], 1'b1}.
  - Increment cnt.
- **Leaving ON.** On the edge where cnt==31 completes, go to END.
  - Quotient = working[31:0]; remainder = working[64:33].
  - Sign fixup for signed mode: negate the quotient when the operand signs differ; the remainder takes the sign of the dividend.
  - Register both into result_o and set ready_o=1.
- **ON with annul_i=1.** Go to FREE on the next edge; result_o and ready_o stay 0. annul_i overrides completion on the same edge.
- **BY_ZERO.** Go to END with result_o = 64'b0 and ready_o = 1. MIPS leaves the result undefined; the team fixes it at zero.
- **END.**
  - While start_i=1: stay, holding result_o and ready_o.
  - When start_i=0: go to FREE; result_o=0 and ready_o=0 on that edge.
  - annul_i in END also forces FREE.
- **Width rules.**
  - Absolute value is two's-complement negation, applied only when signed mode is on and bit31=1.
  - 0x80000000 / 0xFFFFFFFF (signed) yields quotient 0x80000000 and remainder 0. Wrap-around is accepted; no trap.
- **start_i in ON.** Ignored; no restart.

## Timing
- **Reset.** rst=1 on an edge sets state=FREE, cnt=0, working=0, result_o=0, ready_o=0. This applies in any state, including mid-ON.
- **Normal latency.** start_i is high in FREE during cycle 0. ON occupies cycles 1–32. ready_o and the valid result_o are first visible in cycle 33.
- **Zero-divisor latency.** start in cycle 0, BY_ZERO in cycle 1, ready_o=1 in cycle 2.
- **Stall contract.** Execute asserts its stall request whenever start_i=1 and ready_o=0.
- **Back-to-back operation.** After the release edge (END→FREE, start_i=0), a new start is accepted no earlier than the following cycle. The minimum gap between results is therefore 35 cycles (normal case).
- **Combinational paths.** None from inputs to outputs.

## Configuration
- **DIV_SIGNED_EN defined.** Signed mode behaves as described: absolute values are taken and the sign fixup is applied when signed_div_i=1.
- **DIV_SIGNED_EN undefined.**
  - signed_div_i is ignored and every operation is unsigned.
  - The absolute-value and fixup logic is removed.
  - DIV then behaves as DIVU; the decoder must trap DIV as a reserved instruction in that build.

## Test plan
- **Unsigned divide.** DIVU 100/7, start held → ready_o rises in cycle 33; result_o = {0x00000002, 0x0000000E}. Drop start → next cycle ready_o=0, result_o=0.
- **Signed divide, mixed signs.** DIV 0xFFFFFFF9 (−7) / 2 → quotient 0xFFFFFFFD (−3), remainder 0xFFFFFFFF (−1). Also DIV 7/−2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- **Divide by zero.** 5/0 → ready_o=1 in cycle 2, result_o=64'b0; no ON cycles occur.
- **Annul.** Assert annul_i in cycle 10 → state returns to FREE and ready_o never rises. A new start of 9/3 in cycle 12 → ready in cycle 45 with {0, 3}.
- **Corner operands.**
  - DIVU 0xFFFFFFFF/1 → {0, 0xFFFFFFFF}.
  - DIV 0x80000000/0xFFFFFFFF → {0, 0x80000000}.
  - DIVU 3/0xFFFFFFFF → {3, 0}.
- **Reset mid-operation.** rst in cycle 20 → next cycle all outputs 0 and state FREE; the divider does not report ready until a fresh start is issued.
